// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state type, button indices and 7-segment constants for the BCD stopwatch
package stopwatch_pkg;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUN     = 1'b1
    } sw_state_t;

    // Bit positions of the buttons inside the synchroniser vectors.
    localparam int BTN_CLEAR = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;
    localparam int BTN_LAP   = 3;

    // Active-high segment patterns, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_BCD [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_encode(input logic [3:0] bcd);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (bcd <= 4'd9) begin
            pattern = SEG_BCD[bcd];
        end
        return pattern;
    endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// rtl/sw_bcd_digit.sv - one BCD digit register with ripple increment and synchronous clear
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   clear       : synchronous clear to zero (wins over inc_in)
//   inc_in      : advance this digit on the current edge
//   digit       : registered digit value 0..9
//   digit_next  : value the digit takes on the next edge when clear is low
//   carry_out   : inc_in while the digit is 9, feeds the next digit up
module sw_bcd_digit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       inc_in,
    output logic [3:0] digit,
    output logic [3:0] digit_next,
    output logic       carry_out
);

    logic at_nine;

    assign at_nine   = (digit == 4'd9);
    assign carry_out = inc_in & at_nine;

    always_comb begin
        digit_next = digit;
        if (inc_in) begin
            digit_next = at_nine ? 4'd0 : digit + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            digit <= 4'd0;
        end else begin
            digit <= digit_next;
        end
    end

endmodule

// File: rtl/bcd_stopwatch_mux.sv
// rtl/bcd_stopwatch_mux.sv - N-digit BCD stopwatch with lap freeze and multiplexed 7-segment driver
//
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   btn_clear/start/stop/lap : asynchronous push buttons, rising edge acts once
//   seg_n[6:0]            : segments a..g (bit0 = a), active-low
//   dp_n                  : decimal point, active-low
//   digit_sel[N-1:0]      : one-hot digit enable, active-high, digit 0 least significant
//   running               : counter advancing
//   lap_active            : display frozen on lap snapshot
//   overflow              : sticky, set when the count wraps from all nines
module bcd_stopwatch_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 120000,
    parameter int SCAN_DIV   = 1024,
    parameter int DP_POS     = 2,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  btn_clear,
    input  logic                  btn_start,
    input  logic                  btn_stop,
    input  logic                  btn_lap,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  running,
    output logic                  lap_active,
    output logic                  overflow
);

    import stopwatch_pkg::*;

    localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [NUM_DIGITS-1:0] SEL_RESET = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    // Button synchronisers: two flops against metastability, a third for edge detect.
    logic [3:0] btn_raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] sync3;
    logic [3:0] btn_pulse;
    logic       clear_pulse;
    logic       start_pulse;
    logic       stop_pulse;
    logic       lap_pulse;

    assign btn_raw     = {btn_lap, btn_stop, btn_start, btn_clear};
    assign btn_pulse   = sync2 & ~sync3;
    assign clear_pulse = btn_pulse[BTN_CLEAR];
    assign start_pulse = btn_pulse[BTN_START];
    assign stop_pulse  = btn_pulse[BTN_STOP];
    assign lap_pulse   = btn_pulse[BTN_LAP];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Run/stop control
    sw_state_t state_q;
    sw_state_t state_d;

    always_comb begin
        state_d = state_q;
        if (clear_pulse) begin
            state_d = ST_STOPPED;
        end else if (stop_pulse) begin
            state_d = ST_STOPPED;
        end else if (start_pulse) begin
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_STOPPED;
        end else begin
            state_q <= state_d;
        end
    end

    assign running = (state_q == ST_RUN);

    // Prescaler holds in STOPPED so a resume keeps the partial tick.
    logic [PRE_W-1:0] pre_q;
    logic             tick;

    assign tick = running && (pre_q == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clear_pulse) begin
            pre_q <= '0;
        end else if (running) begin
            pre_q <= tick ? '0 : pre_q + PRE_W'(1);
        end
    end

    // BCD count chain; carry[NUM_DIGITS] fires on the all-nines wrap.
    logic [NUM_DIGITS:0]         carry;
    logic [NUM_DIGITS-1:0][3:0]  count;
    logic [NUM_DIGITS-1:0][3:0]  count_next;

    // A tick landing on a clear edge is dropped.
    assign carry[0] = tick & ~clear_pulse;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        sw_bcd_digit u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (clear_pulse),
            .inc_in     (carry[i]),
            .digit      (count[i]),
            .digit_next (count_next[i]),
            .carry_out  (carry[i+1])
        );
    end

    // Lap snapshot and sticky overflow
    logic [NUM_DIGITS-1:0][3:0] snapshot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lap_active <= 1'b0;
            overflow   <= 1'b0;
            snapshot   <= '0;
        end else if (clear_pulse) begin
            lap_active <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (carry[NUM_DIGITS]) begin
                overflow <= 1'b1;
            end
            if (lap_pulse) begin
                if (lap_active) begin
                    lap_active <= 1'b0;
                end else begin
                    lap_active <= 1'b1;
                    // Post-increment value, so a tick on the same edge is captured.
                    snapshot   <= count_next;
                end
            end
        end
    end

    // Display scan
    logic [NUM_DIGITS-1:0][3:0] disp;
    logic [NUM_DIGITS-1:0]      lead_zero;
    logic [SCAN_W-1:0]          scan_q;
    logic [IDX_W-1:0]           idx_q;
    logic [IDX_W-1:0]           idx_next;
    logic                       scan_wrap;
    logic [3:0]                 cur_digit;
    logic                       blank;
    logic [6:0]                 seg_d;
    logic                       dp_d;
    logic [NUM_DIGITS-1:0]      sel_d;

    assign disp      = lap_active ? snapshot : count;
    assign scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        idx_next = idx_q;
        if (scan_wrap) begin
            idx_next = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // lead_zero[i]: digit i and every digit above it are zero.
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        lead_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero     = all_zero && (disp[i] == 4'd0);
            lead_zero[i] = all_zero;
        end
    end

    // Select, segments and dp are all derived from idx_next and registered together.
    always_comb begin
        cur_digit       = disp[idx_next];
        blank           = (LZ_BLANK != 0) && (idx_next != '0) && lead_zero[idx_next];
        seg_d           = blank ? ~SEG_BLANK : ~seg_encode(cur_digit);
        dp_d            = !((DP_POS < NUM_DIGITS) && (int'(idx_next) == DP_POS));
        sel_d           = '0;
        sel_d[idx_next] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_q    <= '0;
            idx_q     <= '0;
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
            digit_sel <= SEL_RESET;
        end else begin
            scan_q    <= scan_wrap ? '0 : scan_q + SCAN_W'(1);
            idx_q     <= idx_next;
            seg_n     <= seg_d;
            dp_n      <= dp_d;
            digit_sel <= sel_d;
        end
    end

endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
// tb/tb_bcd_stopwatch_mux.sv - self-checking bench for bcd_stopwatch_mux (2 digits, fast prescale)
module tb_bcd_stopwatch_mux;

    localparam int ND  = 2;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int DPP = 2;
    localparam int LZ  = 1;

    // Mask order {clear, start, stop, lap}
    localparam logic [3:0] M_NONE  = 4'b0000;
    localparam logic [3:0] M_CLR   = 4'b1000;
    localparam logic [3:0] M_START = 4'b0100;
    localparam logic [3:0] M_STOP  = 4'b0010;
    localparam logic [3:0] M_LAP   = 4'b0001;

    // Active-low digit patterns, bit0 = a.
    localparam bit [6:0] SEG_LO [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_clear = 1'b0;
    logic          btn_start = 1'b0;
    logic          btn_stop = 1'b0;
    logic          btn_lap = 1'b0;
    logic [6:0]    seg_n;
    logic          dp_n;
    logic [ND-1:0] digit_sel;
    logic          running;
    logic          lap_active;
    logic          overflow;

    always #5 clk = ~clk;

    bcd_stopwatch_mux #(
        .NUM_DIGITS (ND),
        .TICK_DIV   (TD),
        .SCAN_DIV   (SD),
        .DP_POS     (DPP),
        .LZ_BLANK   (LZ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_clear  (btn_clear),
        .btn_start  (btn_start),
        .btn_stop   (btn_stop),
        .btn_lap    (btn_lap),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .digit_sel  (digit_sel),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle model of the stopwatch in integer terms
    typedef struct packed {
        bit [3:0] s1;
        bit [3:0] s2;
        bit [3:0] s3;
        bit       run;
        bit       lap;
        bit       ovf;
        int       pre;
        int       cnt;
        int       snap;
        int       scan;
        int       idx;
        bit [6:0] seg;
        bit       dp;
        bit [1:0] sel;
    } ms_t;

    function automatic ms_t model_step(ms_t s, logic rstn, logic [3:0] pins);
        ms_t      n;
        bit [3:0] p;
        bit       tick;
        int       disp;
        int       nxt;
        n = s;
        if (!rstn) begin
            n     = '0;
            n.seg = 7'h7F;
            n.dp  = 1'b1;
            n.sel = 2'b01;
            return n;
        end
        p    = s.s2 & ~s.s3;
        n.s1 = pins;
        n.s2 = s.s1;
        n.s3 = s.s2;
        disp = s.lap ? s.snap : s.cnt;
        if (s.scan == SD - 1) begin
            n.scan = 0;
            n.idx  = (s.idx + 1) % ND;
        end else begin
            n.scan = s.scan + 1;
        end
        n.sel = (n.idx == 0) ? 2'b01 : 2'b10;
        if (n.idx == 0)          n.seg = SEG_LO[disp % 10];
        else if (disp / 10 == 0) n.seg = 7'h7F;
        else                     n.seg = SEG_LO[disp / 10];
        n.dp = 1'b1;
        tick = s.run && (s.pre == TD - 1);
        nxt  = tick ? (s.cnt + 1) % 100 : s.cnt;
        if (p[3]) begin
            n.run = 1'b0;
            n.cnt = 0;
            n.pre = 0;
            n.lap = 1'b0;
            n.ovf = 1'b0;
        end else begin
            if (s.run) n.pre = tick ? 0 : s.pre + 1;
            n.cnt = nxt;
            if (tick && s.cnt == 99) n.ovf = 1'b1;
            if (p[1])      n.run = 1'b0;
            else if (p[2]) n.run = 1'b1;
            if (p[0]) begin
                if (s.lap) begin
                    n.lap = 1'b0;
                end else begin
                    n.lap  = 1'b1;
                    n.snap = nxt;
                end
            end
        end
        return n;
    endfunction

    logic [3:0] pins;
    ms_t        m = '0;
    ms_t        m_next;
    ms_t        sb_q[$];

    assign pins   = {btn_clear, btn_start, btn_stop, btn_lap};
    assign m_next = model_step(m, rst_n, pins);

    always @(posedge clk) begin
        sb_q.push_back(m_next);
        m <= m_next;
    end

    always @(negedge clk) begin
        ms_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_seg_n",     seg_n,      e.seg);
            check("sb_dp_n",      dp_n,       e.dp);
            check("sb_digit_sel", digit_sel,  e.sel);
            check("sb_running",   running,    e.run);
            check("sb_lap",       lap_active, e.lap);
            check("sb_overflow",  overflow,   e.ovf);
        end
    end

    task automatic pulse(input logic [3:0] mk);
        {btn_clear, btn_start, btn_stop, btn_lap} = mk;
        @(negedge clk);
        {btn_clear, btn_start, btn_stop, btn_lap} = 4'b0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int seg_val(input logic [6:0] s, input bit allow_blank);
        for (int k = 0; k < 10; k++) begin
            if (s === SEG_LO[k]) return k;
        end
        if (allow_blank && s === 7'h7F) return 0;
        return -1;
    endfunction

    // Reads both scanned digits; -1 on a bad pattern or a scan that never arrives.
    task automatic read_disp(output int v);
        int d0;
        int d1;
        d0 = -1;
        d1 = -1;
        for (int i = 0; i < 8 && d0 < 0; i++) begin
            if (digit_sel === 2'b01) d0 = seg_val(seg_n, 1'b0);
            if (d0 < 0) @(negedge clk);
        end
        for (int i = 0; i < 8 && d1 < 0; i++) begin
            if (digit_sel === 2'b10) d1 = seg_val(seg_n, 1'b1);
            if (d1 < 0) @(negedge clk);
        end
        v = (d0 < 0 || d1 < 0) ? -1 : d1 * 10 + d0;
    endtask

    typedef struct {
        logic [3:0] mask;
        int         idle;
        logic       run;
        logic       lap;
        logic       ovf;
        int         disp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          v;
        logic [1:0]  sel_s[8];

        vecs[0] = '{M_START, 21, 1'b1, 1'b0, 1'b0, -1};
        vecs[1] = '{M_STOP,   4, 1'b0, 1'b0, 1'b0,  5};
        vecs[2] = '{M_NONE,  20, 1'b0, 1'b0, 1'b0,  5};
        vecs[3] = '{M_START, 25, 1'b1, 1'b0, 1'b0, -1};
        vecs[4] = '{M_LAP,    4, 1'b1, 1'b1, 1'b0, 12};
        vecs[5] = '{M_NONE,  30, 1'b1, 1'b1, 1'b0, 12};
        vecs[6] = '{M_LAP,    4, 1'b1, 1'b0, 1'b0, -1};
        vecs[7] = '{M_CLR,    4, 1'b0, 1'b0, 1'b0,  0};

        rst_n = 1'b0;
        idle(3);
        check("rst_seg_n",     seg_n,      7'h7F);
        check("rst_dp_n",      dp_n,       1'b1);
        check("rst_digit_sel", digit_sel,  2'b01);
        check("rst_running",   running,    1'b0);
        check("rst_lap",       lap_active, 1'b0);
        check("rst_overflow",  overflow,   1'b0);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 8; i++) begin
            pulse(vecs[i].mask);
            idle(vecs[i].idle);
            check($sformatf("vec%0d_running", i),  running,    vecs[i].run);
            check($sformatf("vec%0d_lap", i),      lap_active, vecs[i].lap);
            check($sformatf("vec%0d_overflow", i), overflow,   vecs[i].ovf);
            if (vecs[i].disp >= 0) begin
                read_disp(v);
                check($sformatf("vec%0d_display", i), v, vecs[i].disp);
            end
        end

        // clear + start + stop on one edge while running, then a held start
        pulse(M_START);
        idle(10);
        check("same_edge_pre_running", running, 1'b1);
        pulse(M_CLR | M_START | M_STOP);
        idle(4);
        check("same_edge_running", running, 1'b0);
        read_disp(v);
        check("same_edge_display", v, 0);
        btn_start = 1'b1;
        idle(50);
        check("held_start_running", running, 1'b1);
        btn_stop = 1'b1;
        @(negedge clk);
        btn_stop = 1'b0;
        idle(6);
        check("held_start_no_retrigger", running, 1'b0);
        btn_start = 1'b0;
        idle(4);

        // wrap 99 -> 00 and sticky overflow
        pulse(M_CLR);
        idle(4);
        pulse(M_START);
        idle(410);
        check("ovf_set",     overflow, 1'b1);
        check("ovf_running", running,  1'b1);
        idle(40);
        check("ovf_sticky",  overflow, 1'b1);
        pulse(M_CLR);
        idle(4);
        check("ovf_cleared",       overflow, 1'b0);
        check("ovf_clear_running", running,  1'b0);
        read_disp(v);
        check("ovf_clear_display", v, 0);

        // count 07: scan pattern, blanking and dp
        pulse(M_START);
        idle(28);
        pulse(M_STOP);
        idle(4);
        read_disp(v);
        check("scan_count_07", v, 7);
        for (int i = 0; i < 8; i++) begin
            sel_s[i] = digit_sel;
            check("scan_dp_n", dp_n, 1'b1);
            if (digit_sel === 2'b01) check("scan_seg_digit0", seg_n, 7'h78);
            else                     check("scan_seg_digit1", seg_n, 7'h7F);
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("scan_period_%0d", i), (sel_s[i] !== sel_s[i+2]), 1'b1);
        end

        // reset in the middle of a run
        pulse(M_START);
        idle(10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_seg_n",     seg_n,      7'h7F);
        check("midrst_dp_n",      dp_n,       1'b1);
        check("midrst_digit_sel", digit_sel,  2'b01);
        check("midrst_running",   running,    1'b0);
        check("midrst_lap",       lap_active, 1'b0);
        check("midrst_overflow",  overflow,   1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_stopwatch_mux.md
Name: bcd_stopwatch_mux

Overview:
Parametrised N-digit BCD stopwatch with a multiplexed 7-segment display driver. It generalises the 2-digit stopwatch:
- configurable digit count, tick prescale, scan rate and decimal-point position;
- synchronised, edge-detected buttons;
- lap (display freeze) mode and a sticky overflow flag.

It sits directly behind the dedicated input pins and drives the segment/digit-select Pmod outputs.

Parameters:
NUM_DIGITS, 4, number of BCD digits counted and scanned (2..8)
TICK_DIV, 120000, clk cycles per count increment (>=2)
SCAN_DIV, 1024, clk cycles each digit is displayed before advancing (>=2)
DP_POS, 2, digit index whose decimal point is lit; NUM_DIGITS disables the dp
LZ_BLANK, 1, 1 = blank leading zero digits (digit 0 is never blanked)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
btn_clear  in  1  async button: zero count, stop, exit lap, clear overflow
btn_start  in  1  async button: start counting
btn_stop  in  1  async button: stop counting
btn_lap  in  1  async button: toggle lap freeze
seg_n  out  7  segments a..g (bit0=a), active-low
dp_n  out  1  decimal point, active-low
digit_sel  out  NUM_DIGITS  one-hot digit enable, active-high
running  out  1  counter is advancing
lap_active  out  1  display shows frozen lap snapshot
overflow  out  1  sticky: count wrapped from all-9s

Behaviour:
- Reset (rst_n low at a clk edge) forces the following; all state is synchronous to clk.
  - Outputs: seg_n=7'h7F, dp_n=1, digit_sel=1 (digit 0), running=0, lap_active=0, overflow=0.
  - Internal: count, snapshot, prescaler, scan counter and sync flops all cleared.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then a third flop for rising-edge detect.
  - An action takes effect on the 3rd clk edge after the pin rises.
  - A held level acts once only.
- Control FSM has two states, STOPPED and RUN; running = (state==RUN).
  - STOPPED -> RUN on start_pulse.
  - RUN -> STOPPED on stop_pulse.
  - Start while in RUN, and stop while in STOPPED, are no-ops.
- Same-cycle priority: clear > stop > start. Lap is independent of start/stop but is overridden by clear.
- clear_pulse, same edge:
  - state=STOPPED, count=0, prescaler=0, lap_active=0, overflow=0.
  - A simultaneous tick is discarded.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and holds its value in STOPPED, so resume does not lose a partial tick.
  - At pre==TICK_DIV-1: pre<=0, and count increments on that same edge.
  - First increment occurs TICK_DIV edges after running rises.
- Count: NUM_DIGITS BCD digits, ripple carry within one cycle.
  - Digit 9 -> 0 with carry.
  - All-9s -> all-0 and sets overflow. Counting continues.
- Lap:
  - lap_pulse with lap_active=0 copies count (post-increment value if a tick lands on the same edge) into snapshot and sets lap_active.
  - lap_pulse with lap_active=1 clears lap_active.
  - Lap works in STOPPED and in RUN. The counter keeps running while frozen.
- Display value: snapshot if lap_active, else count.
- Scan:
  - Scan counter counts 0..SCAN_DIV-1. At the terminal value the digit index advances, wrapping NUM_DIGITS-1 -> 0.
  - digit_sel, seg_n and dp_n are registered together from the new index, so there is no ghosting skew.
  - Digit 0 is least significant.
- Segment encoding: 0-9 standard. Non-BCD values cannot occur.
- Blanking:
  - With LZ_BLANK=1, digit i>0 has seg_n=7'h7F when it and all higher digits are 0.
  - dp_n is unaffected by blanking.
- dp_n = 0 only while the index equals DP_POS.
- Scanning runs continuously in every state, including STOPPED.

Decomposition:
- Shared package stopwatch_pkg holds:
  - state enum {ST_STOPPED, ST_RUN};
  - 7-segment constant array SEG_BCD[0:9] (active-high a..g);
  - SEG_BLANK constant.
- One natural sub-module, sw_bcd_digit: a single BCD digit register with inc_in/carry_out and synchronous clear. It is instantiated NUM_DIGITS times via generate.
- Synchronisers, FSM, prescaler, lap and scan stay in the top.

Test Plan (NUM_DIGITS=2, TICK_DIV=4, SCAN_DIV=2, DP_POS=2, LZ_BLANK=1):
1. Reset -> seg_n=7F, digit_sel=01, running=0. Pulse start -> running=1 on 3rd edge; count=01 exactly 4 edges later; count=10 after 40 edges.
2. Run from 00 for 400 edges -> count wraps 99->00, overflow=1 and stays 1. Pulse clear -> count=00, overflow=0, running=0.
3. Run to 05, pulse stop, idle 20 edges -> count stays 05. Pulse start -> 06 arrives after the remaining prescale only, not a full 4 edges.
4. Run to 12, pulse lap -> displayed 12 while count reaches 20. Pulse lap again -> display shows the live count.
5. Assert clear, start and stop on the same edge while running -> STOPPED, count=00. Hold start high for 50 edges -> only one start action.
6. Count=07: digit_sel alternates 01/10 every 2 edges; seg_n shows "7" on digit 0 and 7F (blank) on digit 1; dp_n=1 throughout. Pull rst_n low mid-run -> all outputs return to reset values on that edge.
